// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Issue/write-back bundle between core control, register file and the muldiv unit.
interface muldiv_if;
    import muldiv_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rdIn;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rdOut;
    logic            wbEn;

    modport master (
        output start, funct3, rs1, rs2, rdIn,
        input  busy, done, result, rdOut, wbEn
    );

    modport slave (
        input  start, funct3, rs1, rs2, rdIn,
        output busy, done, result, rdOut, wbEn
    );

endinterface

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on magnitudes.
// hi/lo hold {product_hi, product_lo} for multiply and {remainder, quotient} for divide.
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] b_q;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // The remainder stays below the divisor, so a set top bit of diff means a borrow.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        hi_nxt  = sum[XLEN:1];
        lo_nxt  = {sum[0], lo[XLEN-1:1]};
        if (is_div) begin
            if (!diff[XLEN]) begin
                hi_nxt = diff[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = shifted[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi  <= '0;
            lo  <= '0;
            b_q <= '0;
        end else if (load) begin
            hi  <= '0;
            lo  <= a_mag;
            b_q <= b_mag;
        end else if (step) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: FSM, sign handling, special cases and write-back registers.
// state | meaning: IDLE accepting | CALC iterating | DONE result valid, one-cycle write-back
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int ITER = XLEN
) (
    input logic     Clock,
    input logic     nReset,
    muldiv_if.slave bus
);

    localparam int             CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0]  LAST = CW'(ITER - 1);

    state_e          state;
    logic [CW-1:0]   cnt;
    muldiv_op_e      op_q;
    logic            neg_q;
    logic            neg_r;

    muldiv_op_e      op_in;
    logic            accept;
    logic            a_sgn;
    logic            b_sgn;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] hi_nxt;
    logic [XLEN-1:0] lo_nxt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] final_res;

    always_comb begin
        op_in  = muldiv_op_e'(bus.funct3);
        accept = bus.start && (state != CALC);
        a_sgn  = bus.rs1[XLEN-1] && (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        b_sgn  = bus.rs2[XLEN-1] && (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
        a_mag  = a_sgn ? -bus.rs1 : bus.rs1;
        b_mag  = b_sgn ? -bus.rs2 : bus.rs2;

        special     = 1'b0;
        special_res = '0;
        if (bus.funct3[2] && (bus.rs2 == '0)) begin
            special     = 1'b1;
            special_res = (op_in inside {OP_DIV, OP_DIVU}) ? DIV0_Q : bus.rs1;
        end else if ((op_in inside {OP_DIV, OP_REM}) && (bus.rs1 == INT_MIN) && (bus.rs2 == '1)) begin
            special     = 1'b1;
            special_res = (op_in == OP_DIV) ? INT_MIN : '0;
        end
    end

    muldiv_iter u_iter (
        .clk    (Clock),
        .rst_n  (nReset),
        .load   (accept),
        .step   (state == CALC),
        .is_div (op_q[2]),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    // Sign fix-up uses the values the final iteration is about to write.
    always_comb begin
        prod = {hi_nxt, lo_nxt};
        if (neg_q) prod = -prod;
        case (op_q)
            OP_MUL:           final_res = prod[XLEN-1:0];
            OP_DIV, OP_DIVU:  final_res = neg_q ? -lo_nxt : lo_nxt;
            OP_REM, OP_REMU:  final_res = neg_r ? -hi_nxt : hi_nxt;
            default:          final_res = prod[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= OP_MUL;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.wbEn   <= 1'b0;
            bus.result <= '0;
            bus.rdOut  <= '0;
        end else begin
            bus.done <= 1'b0;
            bus.wbEn <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op_q      <= op_in;
                        neg_q     <= a_sgn ^ b_sgn;
                        neg_r     <= a_sgn;
                        bus.rdOut <= bus.rdIn;
                        cnt       <= '0;
                        if (special) begin
                            state      <= DONE;
                            bus.busy   <= 1'b0;
                            bus.done   <= 1'b1;
                            bus.wbEn   <= (bus.rdIn != '0);
                            bus.result <= special_res;
                        end else begin
                            state    <= CALC;
                            bus.busy <= 1'b1;
                        end
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state      <= DONE;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                        bus.wbEn   <= (bus.rdOut != '0);
                        bus.result <= final_res;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with hand-computed RV32M results.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    muldiv_if bus ();

    muldiv_unit #(.ITER(32)) dut (
        .Clock  (clk),
        .nReset (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.rs1    = a;
        bus.rs2    = b;
        bus.rdIn   = rd;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        if (exp_lat > 0) check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, bus.result, exp);
        check({tag, "_rd"}, 32'(bus.rdOut), 32'(rd));
        check({tag, "_wb"}, 32'(bus.wbEn), 32'(rd != 5'd0));
        @(posedge clk); #1;
        check({tag, "_done_off"}, 32'(bus.done), 32'd0);
        check({tag, "_wb_off"}, 32'(bus.wbEn), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.funct3 = 3'b000;
        bus.rs1    = '0;
        bus.rs2    = '0;
        bus.rdIn   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_wb", 32'(bus.wbEn), 32'd0);
        check("rst_res", bus.result, 32'd0);
        check("rst_rd", 32'(bus.rdOut), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul",     3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 32);
        run_op("mulhu",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 32);
        run_op("mulh",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 32);
        run_op("mulhsu",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF, 32);
        run_op("div",     3'b100, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 32);
        run_op("rem",     3'b110, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 32);
        run_op("divu",    3'b101, 32'd100,       32'd7,         5'd31, 32'd14,        32);
        run_op("remu",    3'b111, 32'd100,       32'd7,         5'd9,  32'd2,         32);
        run_op("div0",    3'b100, 32'd100,       32'd0,         5'd10, 32'hFFFF_FFFF, 0);
        run_op("rem0",    3'b110, 32'd100,       32'd0,         5'd11, 32'h0000_0064, 0);
        run_op("divu0",   3'b101, 32'd5,         32'd0,         5'd12, 32'hFFFF_FFFF, 0);
        run_op("ovf_div", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0);
        run_op("ovf_rem", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 0);

        // start during CALC must be ignored
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.rs1 = 32'd7; bus.rs2 = 32'hFFFF_FFFD; bus.rdIn = 5'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.funct3 = 3'b101; bus.rs1 = 32'd100; bus.rs2 = 32'd7; bus.rdIn = 5'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 5;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("ign_lat", 32'(lat), 32'd32);
        check("ign_res", bus.result, 32'hFFFF_FFEB);
        check("ign_rd", 32'(bus.rdOut), 32'd5);

        // back-to-back: start held in the DONE cycle
        bus.start = 1'b1; bus.funct3 = 3'b111; bus.rs1 = 32'd100; bus.rs2 = 32'd7; bus.rdIn = 5'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_done_off", 32'(bus.done), 32'd0);
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_lat", 32'(lat), 32'd32);
        check("b2b_res", bus.result, 32'd2);
        check("b2b_rd", 32'(bus.rdOut), 32'd3);
        @(posedge clk); #1;

        // reset mid-operation
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.rs1 = 32'd7; bus.rs2 = 32'hFFFF_FFFD; bus.rdIn = 5'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy_pre", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_wb", 32'(bus.wbEn), 32'd0);
        check("mid_rst_res", bus.result, 32'd0);
        check("mid_rst_rd", 32'(bus.rdOut), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.wbEn || bus.busy) seen++;
        end
        check("mid_rst_quiet", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit.
- Sits directly downstream of the register file: it consumes the rs1/rs2 read data.
- Feeds its result back into the register-file write port (rd, dataIn, writeRegMem), producing one write-back per operation.
- Control asserts start with funct3; the unit raises busy, and the core stalls PC/issue until done.

Parameters:
XLEN, 32, operand/result width. Only 32 is supported; the parameter exists for package consistency.
ITER, XLEN, number of iteration cycles for multiply/divide (one bit per cycle).

Ports:
Clock  input  1  system clock, rising edge.
nReset  input  1  asynchronous active-low reset.
start  input  1  request; sampled only when the unit is accepting (IDLE or DONE).
funct3  input  3  RV32M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
rs1  input  XLEN  operand A, from register file rs1.
rs2  input  XLEN  operand B, from register file rs2.
rdIn  input  5  destination register index, captured at start.
busy  output  1  high while in CALC.
done  output  1  one-cycle pulse when the result is valid.
result  output  XLEN  registered result; drive into register-file dataIn.
rdOut  output  5  captured destination; drive into register-file rd.
wbEn  output  1  equals done AND (rdOut != 0); drive into writeRegMem.

Behaviour:
- Reset (async, nReset low):
  - state = IDLE; busy = 0; done = 0; wbEn = 0; result = 0; rdOut = 0; iteration counter = 0.
  - Applies immediately, mid-operation included. The in-flight op is discarded and no write-back occurs.
- FSM states: IDLE, CALC, DONE.
  - IDLE/DONE, start = 1 at edge E0: latch the op, operand magnitudes, sign flags and rdIn.
    - Special case (see below): go to DONE.
    - Otherwise: go to CALC with counter = 0.
  - IDLE/DONE, start = 0: go to IDLE.
  - CALC: one iteration per edge. On the edge where counter == ITER-1, go to DONE.
  - DONE: done = 1 and wbEn = (rdOut != 0) for exactly this one cycle.
    - Back-to-back: start sampled in DONE is accepted on the same edge that leaves DONE.
- Latency:
  - Normal op: iterations occur on E1..E32; done is high in the cycle after E32 (32 cycles after E0).
  - Special case: done is high in the cycle after E0.
- start during CALC: ignored; no queueing, operands not re-latched.
- Multiply:
  - Unsigned shift-add over |A| and |B|, accumulating into a 64-bit product.
  - Signedness: MUL and MULH take both operands signed; MULHSU takes A signed, B unsigned; MULHU takes both unsigned.
  - Final 64-bit product is negated if the operand signs differ (signed operands only).
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide: restoring division on magnitudes.
  - Quotient sign = sign(A) XOR sign(B). Remainder sign = sign(A) (signed ops only).
- Special cases, resolved without CALC:
  - Divisor == 0: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = dividend.
  - Signed overflow (A = 0x80000000, B = 0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- result and rdOut hold their value until the next accepted start; they are not cleared after DONE.
- rdIn == 0: done still pulses; wbEn stays 0.

Decomposition:
- Package muldiv_pkg:
  - muldiv_op_e, the funct3 enum for the 8 RV32M ops.
  - state_e {IDLE, CALC, DONE}.
  - XLEN constant.
  - Helper constants DIV0_Q = 32'hFFFFFFFF and INT_MIN = 32'h80000000.
- One sub-module, muldiv_iter: a registered single-step datapath (add-shift or subtract-shift) selected by an isDiv flag.
  - The top level keeps the FSM, sign handling, special-case detection and output registers.

Test Plan:
- MUL rs1 = 7, rs2 = 0xFFFFFFFD (-3), rdIn = 5 -> done 32 cycles after accept; result = 0xFFFFFFEB; rdOut = 5; wbEn = 1 for one cycle.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> result = 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU same operands -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIV 100 / 0 -> 0xFFFFFFFF, done in the cycle after E0. REM 100 / 0 -> 0x64. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- start pulsed again mid-CALC with different operands -> ignored; first result unchanged. start held in the DONE cycle -> second op accepted; busy high on the next cycle.
- nReset low at iteration 10 -> busy/done/wbEn drop immediately; result = 0; no wbEn pulse. rdIn = 0 op -> done pulses, wbEn stays 0.
